// File: rtl/ultrasonic_echo_responder_pkg.sv
// Shared types and default timing for the HC-SR04 emulator and the controller bench.
// Default timing is in 50 MHz clk_50M cycles.
package ultrasonic_pkg;

  localparam int CNT_W = 22;

  localparam int unsigned TRIG_MIN_CYC_D = 500;
  localparam int unsigned BURST_CYC_D    = 10000;
  localparam int unsigned CYC_PER_CM_D   = 2900;
  localparam int unsigned MAX_CM_D       = 400;
  localparam int unsigned TIMEOUT_CYC_D  = 1900000;
  localparam int unsigned HOLDOFF_CYC_D  = 100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HI,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

endpackage

// File: rtl/ultrasonic_echo_responder_if.sv
// UV_trig/UV_echo sensor bus plus status outputs.
// The master modport is the controller side; the slave modport is the emulated sensor.
interface ultrasonic_echo_responder_if;
  logic       UV_trig;
  logic [8:0] distance_cm;
  logic       UV_echo;
  logic       busy;
  logic       short_trig;
  logic       trig_ignored;
  logic       oor;
  logic [7:0] meas_count;

  modport master (
    output UV_trig, distance_cm,
    input  UV_echo, busy, short_trig, trig_ignored, oor, meas_count
  );

  modport slave (
    input  UV_trig, distance_cm,
    output UV_echo, busy, short_trig, trig_ignored, oor, meas_count
  );
endinterface

// File: rtl/ultrasonic_echo_responder_sync_edge_det.sv
// 2-FF synchronizer for an asynchronous level, with single-cycle rise/fall pulses
// taken between the synchronized level and its one-cycle delay.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_sync_d;
  assign o_fall = ~r_sync & r_sync_d;
endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 emulator: qualifies UV_trig, waits the burst time, then drives an echo
// whose width encodes the distance latched at trig fall.
//
//   state      | meaning
//   IDLE       | waiting for a synchronized trig rising edge
//   TRIG_HI    | measuring trig high width (saturating up-count)
//   BURST      | acoustic burst delay before echo rise
//   ECHO       | UV_echo high for the computed width
//   HOLDOFF    | dead time before the next trig is accepted
module ultrasonic_echo_responder
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYC = TRIG_MIN_CYC_D,
  parameter int unsigned BURST_CYC    = BURST_CYC_D,
  parameter int unsigned CYC_PER_CM   = CYC_PER_CM_D,
  parameter int unsigned MAX_CM       = MAX_CM_D,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_D,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_D
) (
  input logic                        clk_50M,
  input logic                        rst_n,
  ultrasonic_echo_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_TMIN    = CNT_W'(TRIG_MIN_CYC);
  // BURST lasts one cycle less than BURST_CYC: the fall-detect cycle is the first.
  localparam logic [CNT_W-1:0] L_BURST   = CNT_W'(BURST_CYC - 2);
  localparam logic [CNT_W-1:0] L_CPC     = CNT_W'(CYC_PER_CM);
  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] L_HOLD    = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [8:0]       L_MAX_CM  = 9'(MAX_CM);

  logic w_rise;
  logic w_fall;

  sync_edge_det u_trig_sync (
    .clk     (clk_50M),
    .rst_n   (rst_n),
    .i_async (bus.UV_trig),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [8:0]       r_dist;
  logic             r_echo;
  logic             r_busy;
  logic             r_short;
  logic             r_ign;
  logic             r_oor;
  logic [7:0]       r_meas;

  logic             w_oor;
  logic [CNT_W-1:0] w_prod;
  logic [CNT_W-1:0] w_width;

  assign w_oor   = (r_dist == 9'd0) || (r_dist > L_MAX_CM);
  assign w_prod  = CNT_W'(r_dist) * L_CPC;
  assign w_width = w_oor ? L_TIMEOUT : w_prod;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dist  <= '0;
      r_echo  <= 1'b0;
      r_busy  <= 1'b0;
      r_short <= 1'b0;
      r_ign   <= 1'b0;
      r_oor   <= 1'b0;
      r_meas  <= '0;
    end else begin
      r_short <= 1'b0;
      r_ign   <= 1'b0;
      r_oor   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_TRIG_HI;
            r_cnt   <= L_ONE;
          end
        end
        ST_TRIG_HI: begin
          if (w_fall) begin
            if (r_cnt >= L_TMIN) begin
              r_state <= ST_BURST;
              r_cnt   <= L_BURST;
              r_dist  <= bus.distance_cm;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_short <= 1'b1;
            end
          end else if (r_cnt < L_TMIN) begin
            r_cnt <= r_cnt + L_ONE;
          end
        end
        ST_BURST: begin
          r_ign <= w_rise;
          if (r_cnt == '0) begin
            r_state <= ST_ECHO;
            r_cnt   <= w_width - L_ONE;
            r_echo  <= 1'b1;
            r_oor   <= w_oor;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        ST_ECHO: begin
          r_ign <= w_rise;
          if (r_cnt == '0) begin
            r_state <= ST_HOLDOFF;
            r_cnt   <= L_HOLD;
            r_echo  <= 1'b0;
            r_meas  <= r_meas + 8'd1;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        ST_HOLDOFF: begin
          r_ign <= w_rise;
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.UV_echo      = r_echo;
  assign bus.busy         = r_busy;
  assign bus.short_trig   = r_short;
  assign bus.trig_ignored = r_ign;
  assign bus.oor          = r_oor;
  assign bus.meas_count   = r_meas;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder with shortened timing parameters;
// stimulus queues the expected echo, a negedge monitor checks each echo as it appears.
module tb_ultrasonic_echo_responder;
  localparam int TMIN  = 20;
  localparam int BURST = 50;
  localparam int CPC   = 3;
  localparam int MAXCM = 400;
  localparam int TOUT  = 500;
  localparam int HOLD  = 40;

  typedef struct {
    int     width;
    bit     oor;
    int     meas;
    longint fall_cyc;
  } exp_t;

  logic   clk_50M = 1'b0;
  logic   rst_n   = 1'b0;
  longint cyc     = 0;
  int     n_vec   = 0;
  int     n_err   = 0;
  int     n_short = 0;
  int     n_ign   = 0;
  int     exp_meas = 0;
  exp_t   q[$];

  ultrasonic_echo_responder_if u_if ();

  ultrasonic_echo_responder #(
    .TRIG_MIN_CYC (TMIN),
    .BURST_CYC    (BURST),
    .CYC_PER_CM   (CPC),
    .MAX_CM       (MAXCM),
    .TIMEOUT_CYC  (TOUT),
    .HOLDOFF_CYC  (HOLD)
  ) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .bus     (u_if)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected echo at each rise, checks delay/oor there and width/count at fall.
  exp_t cur;
  bit   in_echo   = 0;
  bit   prev_echo = 0;
  int   w_cnt     = 0;

  always @(negedge clk_50M) begin
    if (!rst_n) begin
      in_echo   = 0;
      prev_echo = 0;
    end else begin
      if (u_if.short_trig)   n_short++;
      if (u_if.trig_ignored) n_ign++;
      if (u_if.UV_echo && !prev_echo) begin
        if (q.size() == 0) begin
          check("unexpected_echo", 1, 0);
        end else begin
          cur     = q.pop_front();
          in_echo = 1;
          w_cnt   = 1;
          check("echo_delay", cyc - cur.fall_cyc, BURST + 2);
          check("oor_at_rise", u_if.oor, cur.oor);
          check("busy_at_rise", u_if.busy, 1);
        end
      end else if (u_if.UV_echo) begin
        w_cnt++;
        if (u_if.oor) check("stray_oor", 1, 0);
      end else if (prev_echo && in_echo) begin
        check("echo_width", w_cnt, cur.width);
        check("meas_count", u_if.meas_count, cur.meas);
        in_echo = 0;
      end
      prev_echo = u_if.UV_echo;
    end
  end

  task automatic pulse_trig(input int h);
    @(posedge clk_50M); #1;
    u_if.UV_trig = 1'b1;
    repeat (h) @(posedge clk_50M);
    #1 u_if.UV_trig = 1'b0;
  endtask

  task automatic start_meas(input int d, input int h);
    exp_t e;
    int   w;
    bit   o;
    o = (d == 0) || (d > MAXCM);
    w = o ? TOUT : d * CPC;
    exp_meas = (exp_meas + 1) % 256;
    e.width = w; e.oor = o; e.meas = exp_meas; e.fall_cyc = 0;
    u_if.distance_cm = 9'(d);
    q.push_back(e);
    pulse_trig(h);
    q[q.size()-1].fall_cyc = cyc;
  endtask

  task automatic wait_idle();
    repeat (4) @(posedge clk_50M);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_50M);
      if (!u_if.busy) break;
    end
    check("idle_reached", u_if.busy, 0);
  endtask

  task automatic wait_echo(input logic lvl);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_50M);
      if (u_if.UV_echo == lvl) break;
    end
    check("echo_level_reached", u_if.UV_echo, lvl);
  endtask

  initial begin
    int s0, i0;
    u_if.UV_trig     = 1'b0;
    u_if.distance_cm = 9'd0;
    repeat (3) @(negedge clk_50M);
    check("rst_echo", u_if.UV_echo, 0);
    check("rst_busy", u_if.busy, 0);
    check("rst_meas", u_if.meas_count, 0);
    check("rst_pulses", {u_if.short_trig, u_if.trig_ignored, u_if.oor}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    start_meas(10, 25); wait_idle();

    s0 = n_short;
    pulse_trig(10);
    repeat (3) @(negedge clk_50M);
    check("short_busy", u_if.busy, 0);
    repeat (5) @(negedge clk_50M);
    check("short_pulse_count", n_short - s0, 1);
    pulse_trig(TMIN - 1);
    repeat (8) @(negedge clk_50M);
    check("short_boundary_count", n_short - s0, 2);
    check("short_meas_unchanged", u_if.meas_count, exp_meas);

    start_meas(7, TMIN); wait_idle();
    start_meas(0, 25);   wait_idle();
    start_meas(401, 25); wait_idle();
    start_meas(400, 25); wait_idle();
    start_meas(1, 25);   wait_idle();

    // trig while busy: mid-ECHO, mid-HOLDOFF, and held high across holdoff end
    i0 = n_ign; s0 = n_short;
    start_meas(100, 25);
    wait_echo(1'b1);
    repeat (50) @(posedge clk_50M);
    pulse_trig(25);
    wait_echo(1'b0);
    repeat (5) @(posedge clk_50M);
    pulse_trig(5);
    repeat (5) @(posedge clk_50M);
    #1 u_if.UV_trig = 1'b1;
    wait_idle();
    repeat (10) @(posedge clk_50M);
    #1 u_if.UV_trig = 1'b0;
    repeat (10) @(negedge clk_50M);
    check("ignored_count", n_ign - i0, 3);
    check("held_trig_not_accepted", u_if.busy, 0);
    check("held_trig_no_short", n_short - s0, 0);
    repeat (100) @(negedge clk_50M);

    start_meas(10, 25);
    repeat (10) @(posedge clk_50M);
    #1 u_if.distance_cm = 9'd50;
    wait_idle();

    start_meas(100, 25);
    wait_echo(1'b1);
    repeat (20) @(posedge clk_50M);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_echo", u_if.UV_echo, 0);
    check("rst_mid_busy", u_if.busy, 0);
    check("rst_mid_meas", u_if.meas_count, 0);
    exp_meas = 0;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);
    start_meas(10, 25); wait_idle();

    for (int k = 0; k < 255; k++) begin
      start_meas(1, TMIN);
      wait_idle();
    end
    check("meas_wrap", u_if.meas_count, 0);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
